// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction memory handshake, IF/ID register outputs.
// The stage connects through the master modport, its environment through the slave modport.
interface if_stage_if;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_ins;
  logic        ifid_valid;

  modport master (
    input  PCWrite, IFIDWrite, branch_taken, branch_target, imem_rdata, imem_ready,
    output imem_req, imem_addr, ifid_pc, ifid_ins, ifid_valid
  );

  modport slave (
    output PCWrite, IFIDWrite, branch_taken, branch_target, imem_rdata, imem_ready,
    input  imem_req, imem_addr, ifid_pc, ifid_ins, ifid_valid
  );
endinterface

// File: rtl/if_stage.sv
// RV32I fetch stage: PC, instruction memory request, one-entry stall buffer, IF/ID register; 1-cycle fetch-to-IF/ID.
// Stalls (PCWrite/IFIDWrite low) park a returned instruction in the buffer and drop the request; a branch flush overrides.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus
);

  typedef enum logic {WAIT, BUF} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_ins;
  logic        req;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_ins;
  logic        ifid_valid;

  logic        go;
  logic        avail;
  logic [31:0] ins;

  // A mismatched PCWrite/IFIDWrite pair is conservatively a stall.
  assign go    = bus.PCWrite & bus.IFIDWrite;
  assign avail = (state == BUF) | (req & bus.imem_ready);
  assign ins   = (state == BUF) ? buf_ins : bus.imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      state      <= WAIT;
      buf_ins    <= 32'h0;
      req        <= 1'b0;
      ifid_pc    <= 32'h0;
      ifid_ins   <= NOP_INS;
      ifid_valid <= 1'b0;
    end else if (bus.branch_taken) begin
      pc         <= bus.branch_target;
      state      <= WAIT;
      req        <= 1'b1;
      ifid_pc    <= 32'h0;
      ifid_ins   <= NOP_INS;
      ifid_valid <= 1'b0;
    end else if (avail && go) begin
      pc         <= pc + 32'd4;
      state      <= WAIT;
      req        <= 1'b1;
      ifid_pc    <= pc;
      ifid_ins   <= ins;
      ifid_valid <= 1'b1;
    end else if (avail) begin
      // Park the returned instruction; in BUF everything simply holds.
      if (state == WAIT) begin
        buf_ins <= bus.imem_rdata;
        state   <= BUF;
        req     <= 1'b0;
      end
    end else begin
      req <= 1'b1;
      if (bus.IFIDWrite) begin
        ifid_pc    <= pc;
        ifid_ins   <= NOP_INS;
        ifid_valid <= 1'b0;
      end
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.ifid_pc    = ifid_pc;
  assign bus.ifid_ins   = ifid_ins;
  assign bus.ifid_valid = ifid_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming fetch, memory wait, stall buffering, flush, PC wrap, async reset.
module tb_if_stage;
  logic clk;
  logic rst_n;
  logic garbage;
  int   total;
  int   bad;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns addr|0x100; 'garbage' replaces it to prove the stage ignores rdata.
  assign bus.imem_rdata = garbage ? 32'hDEAD_BEEF : (bus.imem_addr | 32'h0000_0100);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] p, input logic [31:0] i, input logic v);
    chk({tag, ".pc"}, bus.ifid_pc, p);
    chk({tag, ".ins"}, bus.ifid_ins, i);
    chk({tag, ".valid"}, {31'h0, bus.ifid_valid}, {31'h0, v});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    garbage = 1'b0;
    rst_n = 1'b0;
    bus.PCWrite       = 1'b1;
    bus.IFIDWrite     = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.imem_ready    = 1'b1;

    step();
    step();
    chk("rst.req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst.addr", bus.imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h13, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("c1.req", {31'h0, bus.imem_req}, 32'h1);
    chk("c1.addr", bus.imem_addr, 32'h0);
    chk_ifid("c1", 32'h0, 32'h13, 1'b0);
    step();
    chk_ifid("c2", 32'h0, 32'h100, 1'b1);
    chk("c2.addr", bus.imem_addr, 32'h4);
    step();
    chk_ifid("c3", 32'h4, 32'h104, 1'b1);
    chk("c3.addr", bus.imem_addr, 32'h8);

    // Memory not ready for three cycles at pc=0x8: bubbles.
    bus.imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ifid("wait", 32'h8, 32'h13, 1'b0);
      chk("wait.addr", bus.imem_addr, 32'h8);
    end
    bus.imem_ready = 1'b1;
    step();
    chk_ifid("wait_done", 32'h8, 32'h108, 1'b1);
    chk("wait_done.addr", bus.imem_addr, 32'hC);

    // Stall while 0x10C returns: buffered, request dropped, IF/ID holds.
    bus.PCWrite   = 1'b0;
    bus.IFIDWrite = 1'b0;
    step();
    chk("stall1.req", {31'h0, bus.imem_req}, 32'h0);
    chk("stall1.addr", bus.imem_addr, 32'hC);
    chk_ifid("stall1", 32'h8, 32'h108, 1'b1);
    garbage = 1'b1;
    step();
    chk("stall2.req", {31'h0, bus.imem_req}, 32'h0);
    chk_ifid("stall2", 32'h8, 32'h108, 1'b1);
    bus.PCWrite   = 1'b1;
    bus.IFIDWrite = 1'b1;
    step();
    garbage = 1'b0;
    chk_ifid("release", 32'hC, 32'h10C, 1'b1);
    chk("release.addr", bus.imem_addr, 32'h10);
    chk("release.req", {31'h0, bus.imem_req}, 32'h1);

    // Buffer 0x110 under stall, then flush to 0x40 while still stalled.
    bus.PCWrite   = 1'b0;
    bus.IFIDWrite = 1'b0;
    step();
    chk("buf2.req", {31'h0, bus.imem_req}, 32'h0);
    chk_ifid("buf2", 32'hC, 32'h10C, 1'b1);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    step();
    bus.branch_taken = 1'b0;
    chk("flush.addr", bus.imem_addr, 32'h40);
    chk("flush.req", {31'h0, bus.imem_req}, 32'h1);
    chk_ifid("flush", 32'h0, 32'h13, 1'b0);
    bus.PCWrite   = 1'b1;
    bus.IFIDWrite = 1'b1;
    step();
    chk_ifid("post_flush", 32'h40, 32'h140, 1'b1);
    chk("post_flush.addr", bus.imem_addr, 32'h44);

    // PC wrap at the top of the address space.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    step();
    bus.branch_taken = 1'b0;
    chk("wrap_tgt.addr", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    chk_ifid("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    chk("wrap.addr", bus.imem_addr, 32'h0);
    step();
    chk_ifid("after_wrap", 32'h0, 32'h100, 1'b1);
    chk("after_wrap.addr", bus.imem_addr, 32'h4);

    // Mismatched pair stalls: 0x104 buffered.
    bus.PCWrite = 1'b0;
    step();
    chk("mismatch.req", {31'h0, bus.imem_req}, 32'h0);
    chk("mismatch.addr", bus.imem_addr, 32'h4);
    chk_ifid("mismatch", 32'h0, 32'h100, 1'b1);

    // Asynchronous reset mid-cycle while in BUF.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.req", {31'h0, bus.imem_req}, 32'h0);
    chk("arst.addr", bus.imem_addr, 32'h0);
    chk_ifid("arst", 32'h0, 32'h13, 1'b0);
    bus.PCWrite = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rerun1.req", {31'h0, bus.imem_req}, 32'h1);
    chk_ifid("rerun1", 32'h0, 32'h13, 1'b0);
    step();
    chk_ifid("rerun2", 32'h0, 32'h100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
